// File: rtl/mrt_pkg.sv
// Shared MinRoot types: iteration/polynomial widths and the per-lane scheduler state.
package mrt_pkg;
  localparam int IterBits = 16;
  localparam int PolyBits = 32;

  typedef logic [PolyBits-1:0] poly_t;

  typedef enum logic [1:0] {
    LANE_IDLE,
    LANE_START,
    LANE_RUN,
    LANE_DONE
  } lane_state_e;
endpackage

// File: rtl/mrt_rr_arbiter.sv
// Round-robin one-hot grant; the priority pointer moves past the granted requester on advance.
module mrt_rr_arbiter #(
  parameter int N = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);
  localparam int PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_ptr_nxt;

  // Winner is the requester with the smallest circular distance from the pointer.
  always_comb begin
    int best;
    int sel;
    int d;
    best      = N;
    sel       = 0;
    d         = 0;
    any_o     = 1'b0;
    gnt_o     = '0;
    w_ptr_nxt = r_ptr;
    for (int i = 0; i < N; i++) begin
      d = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + N - int'(r_ptr));
      if (req_i[i] && d < best) begin
        best = d;
        sel  = i;
      end
    end
    any_o = (best < N);
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = any_o && (sel == i);
    end
    w_ptr_nxt = (sel == N - 1) ? '0 : PtrW'(sel + 1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (advance_i && any_o) begin
      r_ptr <= w_ptr_nxt;
    end
  end
endmodule

// File: rtl/minroot_job_scheduler.sv
// Dispatches MinRoot jobs onto N engine lanes and returns each lane's final x/y with its tag.
module minroot_job_scheduler
  import mrt_pkg::*;
#(
  parameter int N       = 1,
  parameter int TagBits = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             job_valid_i,
  output logic                             job_ready_o,
  input  logic [TagBits-1:0]               job_tag_i,
  input  logic [IterBits-1:0]              job_start_iter_i,
  input  logic [IterBits-1:0]              job_iters_i,
  input  poly_t                            job_x_i,
  input  poly_t                            job_y_i,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic [TagBits-1:0]               res_tag_o,
  output poly_t                            res_x_o,
  output poly_t                            res_y_o,
  output logic [N-1:0]                     eng_start_o,
  output logic [N-1:0][IterBits-1:0]       eng_start_iter_o,
  output logic [N-1:0][IterBits-1:0]       eng_iters_o,
  output poly_t [N-1:0]                    eng_x_o,
  output poly_t [N-1:0]                    eng_y_o,
  input  poly_t [N-1:0]                    eng_x_i,
  input  poly_t [N-1:0]                    eng_y_i,
  input  logic [N-1:0]                     eng_done_i,
  output logic [$clog2(N+1)-1:0]           busy_lanes_o
);
  localparam int BusyW = $clog2(N + 1);

  typedef struct packed {
    logic [TagBits-1:0]  tag;
    logic [IterBits-1:0] start_iter;
    logic [IterBits-1:0] iters;
    poly_t               x;
    poly_t               y;
  } job_t;

  lane_state_e r_state [N];
  lane_state_e w_state_nxt [N];
  job_t        r_job [N];
  poly_t       r_rx [N];
  poly_t       r_ry [N];

  logic [N-1:0]       w_idle, w_done, w_sel, w_req, w_gnt;
  logic [N-1:0]       r_res_oh;
  logic               w_any, w_accept, w_res_hs, w_load, w_ready_nxt;
  logic               r_job_ready, r_res_valid;
  logic [TagBits-1:0] r_res_tag, w_tag;
  poly_t              r_res_x, r_res_y, w_x, w_y;
  logic [BusyW-1:0]   r_busy, w_busy_nxt;

  assign w_accept = job_valid_i & r_job_ready;
  assign w_res_hs = r_res_valid & res_ready_i;
  assign w_load   = ~r_res_valid | w_res_hs;
  // The lane already presented on the output stays DONE until its handshake; keep it out of arbitration.
  assign w_req    = w_done & ~r_res_oh;

  always_comb begin
    w_idle           = '0;
    w_done           = '0;
    eng_start_o      = '0;
    eng_start_iter_o = '0;
    eng_iters_o      = '0;
    eng_x_o          = '0;
    eng_y_o          = '0;
    for (int i = 0; i < N; i++) begin
      w_idle[i]           = (r_state[i] == LANE_IDLE);
      w_done[i]           = (r_state[i] == LANE_DONE);
      eng_start_o[i]      = (r_state[i] == LANE_START);
      eng_start_iter_o[i] = r_job[i].start_iter;
      eng_iters_o[i]      = r_job[i].iters;
      eng_x_o[i]          = r_job[i].x;
      eng_y_o[i]          = r_job[i].y;
    end
  end

  // Lowest-index idle lane wins the incoming job.
  always_comb begin
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_idle[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    int cnt;
    cnt         = 0;
    w_ready_nxt = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        LANE_IDLE:  if (w_accept && w_sel[i])
                      w_state_nxt[i] = (job_iters_i == '0) ? LANE_DONE : LANE_START;
        LANE_START: w_state_nxt[i] = LANE_RUN;
        LANE_RUN:   if (eng_done_i[i]) w_state_nxt[i] = LANE_DONE;
        LANE_DONE:  if (w_res_hs && r_res_oh[i]) w_state_nxt[i] = LANE_IDLE;
        default:    w_state_nxt[i] = LANE_IDLE;
      endcase
      if (w_state_nxt[i] != LANE_IDLE) cnt++;
      else                             w_ready_nxt = 1'b1;
    end
    w_busy_nxt = BusyW'(cnt);
  end

  always_comb begin
    w_tag = '0;
    w_x   = '0;
    w_y   = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_tag = r_job[i].tag;
        w_x   = r_rx[i];
        w_y   = r_ry[i];
      end
    end
  end

  mrt_rr_arbiter #(.N(N)) u_res_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (w_req),
    .advance_i (w_load),
    .gnt_o     (w_gnt),
    .any_o     (w_any)
  );

  // Result regs preload with the job's x/y so a zero-iteration job returns its inputs unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= LANE_IDLE;
        r_job[i]   <= '0;
        r_rx[i]    <= '0;
        r_ry[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (w_idle[i] && w_accept && w_sel[i]) begin
          r_job[i].tag        <= job_tag_i;
          r_job[i].start_iter <= job_start_iter_i;
          r_job[i].iters      <= job_iters_i;
          r_job[i].x          <= job_x_i;
          r_job[i].y          <= job_y_i;
          r_rx[i]             <= job_x_i;
          r_ry[i]             <= job_y_i;
        end else if (r_state[i] == LANE_RUN && eng_done_i[i]) begin
          r_rx[i] <= eng_x_i[i];
          r_ry[i] <= eng_y_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_job_ready <= 1'b0;
      r_busy      <= '0;
      r_res_valid <= 1'b0;
      r_res_oh    <= '0;
      r_res_tag   <= '0;
      r_res_x     <= '0;
      r_res_y     <= '0;
    end else begin
      r_job_ready <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      if (w_load) begin
        r_res_valid <= w_any;
        r_res_oh    <= w_gnt;
        if (w_any) begin
          r_res_tag <= w_tag;
          r_res_x   <= w_x;
          r_res_y   <= w_y;
        end
      end
    end
  end

  assign job_ready_o  = r_job_ready;
  assign busy_lanes_o = r_busy;
  assign res_valid_o  = r_res_valid;
  assign res_tag_o    = r_res_tag;
  assign res_x_o      = r_res_x;
  assign res_y_o      = r_res_y;
endmodule
